// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch PC unit and its next-PC selector.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    TRAP  = 2'd3
  } pc_state_t;

  localparam int unsigned INSN_BYTES   = 4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_PC  = 32'h0000_0100;

  // Sequential successor; wraps modulo 2^32 with no carry out.
  function automatic logic [31:0] pcInc(input logic [31:0] pc);
    return pc + 32'(INSN_BYTES);
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection: JALR bit-0 clear, alignment check and PC mux.
module next_pc_sel
  import pc_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        branchOut,
  input  logic [31:0] target,
  input  logic        isJalr,
  input  logic [31:0] trapPc,
  output logic [31:0] nextPc,
  output logic [31:0] effTarget,
  output logic        taken,
  output logic        misaligned
);

  always_comb begin
    effTarget  = {target[31:1], target[0] & ~isJalr};
    misaligned = branchOut && (effTarget[1:0] != 2'b00);
    taken      = branchOut && !misaligned;
    if (misaligned)  nextPc = trapPc;
    else if (taken)  nextPc = effTarget;
    else             nextPc = pcInc(pc);
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Architectural PC register and fetch sequencer with misaligned-target trap.
// Optional PC_STATS_EN macro adds accept / taken-accept counters.
module fetch_pc_unit
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] TRAP_PC  = DEF_TRAP_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_out_i,
  input  logic [31:0] target_i,
  input  logic        is_jalr_i,
  input  logic        imem_ready_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        fetch_valid_o,
  output logic        redirect_o,
  output logic        misalign_o,
  output logic [31:0] fault_addr_o
`ifdef PC_STATS_EN
  ,
  output logic [31:0] accept_cnt_o,
  output logic [31:0] taken_cnt_o
`endif
);

  pc_state_t   state;
  logic        accept;
  logic [31:0] nextPc;
  logic [31:0] effTarget;
  logic        taken;
  logic        misaligned;

  assign accept     = (state == FETCH) && imem_ready_i && !stall_i;
  assign pc_plus4_o = pcInc(pc_o);

  next_pc_sel uSel (
    .pc         (pc_o),
    .branchOut  (branch_out_i),
    .target     (target_i),
    .isJalr     (is_jalr_i),
    .trapPc     (TRAP_PC),
    .nextPc     (nextPc),
    .effTarget  (effTarget),
    .taken      (taken),
    .misaligned (misaligned)
  );

  // fetch_valid_o is registered alongside the state so it is 1 exactly in FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= BOOT;
      pc_o          <= RESET_PC;
      fetch_valid_o <= 1'b0;
      redirect_o    <= 1'b0;
      misalign_o    <= 1'b0;
      fault_addr_o  <= '0;
    end else begin
      redirect_o <= 1'b0;
      unique case (state)
        BOOT: begin
          state         <= FETCH;
          fetch_valid_o <= 1'b1;
        end
        FETCH: begin
          if (stall_i) begin
            state         <= HOLD;
            fetch_valid_o <= 1'b0;
          end else if (imem_ready_i) begin
            pc_o <= nextPc;
            if (misaligned) begin
              state         <= TRAP;
              fetch_valid_o <= 1'b0;
              misalign_o    <= 1'b1;
              fault_addr_o  <= effTarget;
            end else begin
              redirect_o <= taken;
            end
          end
        end
        HOLD: begin
          if (!stall_i) begin
            state         <= FETCH;
            fetch_valid_o <= 1'b1;
          end
        end
        TRAP: begin
          state         <= FETCH;
          fetch_valid_o <= 1'b1;
        end
        default: begin
          state         <= BOOT;
          fetch_valid_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_STATS_EN
  // Taken count includes trap-causing accepts, i.e. any accepted branchOut.
  always_ff @(posedge clk) begin
    if (rst) begin
      accept_cnt_o <= '0;
      taken_cnt_o  <= '0;
    end else if (accept) begin
      accept_cnt_o <= accept_cnt_o + 32'd1;
      if (branch_out_i) taken_cnt_o <= taken_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed plan plus randomized traffic
// against a behavioural model of the fetch rules.
module tb_fetch_pc_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] TRP_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst, stall, br, jl, rdy;
  logic [31:0] tg;
  logic [31:0] pc, pcPlus4, fault;
  logic        fv, redir, mis;
`ifdef PC_STATS_EN
  logic [31:0] accCnt, takCnt;
`endif

  int nChecks = 0;
  int nErrors = 0;

  always #5 clk = ~clk;

  fetch_pc_unit #(.RESET_PC(RST_PC), .TRAP_PC(TRP_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall),
    .branch_out_i  (br),
    .target_i      (tg),
    .is_jalr_i     (jl),
    .imem_ready_i  (rdy),
    .pc_o          (pc),
    .pc_plus4_o    (pcPlus4),
    .fetch_valid_o (fv),
    .redirect_o    (redir),
    .misalign_o    (mis),
    .fault_addr_o  (fault)
`ifdef PC_STATS_EN
    ,
    .accept_cnt_o  (accCnt),
    .taken_cnt_o   (takCnt)
`endif
  );

  // Behavioural model: "fetching" means requests are live; "holding" means
  // parked on a stall; neither means a one-cycle warm-up (after reset or trap).
  logic        mFetching, mHolding, mRedirect, mMis;
  logic [31:0] mPc, mFault, mAcc, mTaken;

  function automatic logic [31:0] effOf(input logic [31:0] t, input logic j);
    return j ? t - (t % 2) : t;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mPc <= RST_PC; mFetching <= 0; mHolding <= 0; mRedirect <= 0;
      mMis <= 0; mFault <= 0; mAcc <= 0; mTaken <= 0;
    end else begin
      mRedirect <= 0;
      if (mFetching) begin
        if (stall) begin
          mFetching <= 0; mHolding <= 1;
        end else if (rdy) begin
          mAcc <= mAcc + 1;
          if (br) begin
            mTaken <= mTaken + 1;
            if (effOf(tg, jl) % 4 == 0) begin
              mPc <= effOf(tg, jl); mRedirect <= 1;
            end else begin
              mPc <= TRP_PC; mMis <= 1; mFault <= effOf(tg, jl); mFetching <= 0;
            end
          end else begin
            mPc <= mPc + 4;
          end
        end
      end else if (mHolding) begin
        if (!stall) begin mHolding <= 0; mFetching <= 1; end
      end else begin
        mFetching <= 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareAll();
    chk("pc", pc, mPc);
    chk("pc_plus4", pcPlus4, mPc + 32'd4);
    chk("fetch_valid", 32'(fv), 32'(mFetching));
    chk("redirect", 32'(redir), 32'(mRedirect));
    chk("misalign", 32'(mis), 32'(mMis));
    chk("fault_addr", fault, mFault);
`ifdef PC_STATS_EN
    chk("accept_cnt", accCnt, mAcc);
    chk("taken_cnt", takCnt, mTaken);
`endif
  endtask

  // One clock: drive inputs, take the edge, then compare 1 time unit later.
  task automatic cyc(input logic r, input logic st, input logic b, input logic j,
                     input logic rd, input logic [31:0] t);
    rst = r; stall = st; br = b; jl = j; rdy = rd; tg = t;
    @(posedge clk);
    #1;
    compareAll();
  endtask

  initial begin
    rst = 1; stall = 0; br = 0; jl = 0; rdy = 0; tg = '0;
    @(negedge clk);

    // Reset, BOOT, then sequential fetch.
    cyc(1, 0, 0, 0, 1, 0);
    chk("reset pc", pc, 32'h0);
    chk("reset fv", 32'(fv), 32'd0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("boot pc", pc, 32'h0);
    chk("boot->fetch fv", 32'(fv), 32'd1);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("seq pc 12", pc, 32'hC);
    cyc(0, 0, 0, 0, 1, 0);
    chk("seq pc 16", pc, 32'h10);

    // Taken branch and one-cycle redirect pulse.
    cyc(0, 0, 1, 0, 1, 32'h40);
    chk("branch pc", pc, 32'h40);
    chk("redirect hi", 32'(redir), 32'd1);
    cyc(0, 0, 0, 0, 1, 0);
    chk("redirect lo", 32'(redir), 32'd0);

    // JALR bit-0 clear, then misaligned trap.
    cyc(0, 0, 1, 1, 1, 32'h81);
    chk("jalr pc", pc, 32'h80);
    chk("jalr no trap", 32'(mis), 32'd0);
    cyc(0, 0, 1, 1, 1, 32'h82);
    chk("trap pc", pc, 32'h100);
    chk("trap flag", 32'(mis), 32'd1);
    chk("trap fault", fault, 32'h82);
    cyc(0, 0, 0, 0, 1, 0);
    chk("post-trap fv", 32'(fv), 32'd1);
    cyc(0, 0, 0, 0, 1, 0);
    chk("post-trap pc", pc, 32'h104);
    chk("sticky misalign", 32'(mis), 32'd1);

    // Walk to 0x20, stall three cycles with a pending branch.
    cyc(1, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1, 0);
    chk("pc 0x20", pc, 32'h20);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, 0, 1, 32'h40);
      chk("stall pc", pc, 32'h20);
      chk("stall fv", 32'(fv), 32'd0);
      chk("stall no redirect", 32'(redir), 32'd0);
    end
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("release pc", pc, 32'h24);

    // Memory not ready holds the PC, then wrap-around.
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("not ready pc", pc, 32'h24);
    chk("not ready fv", 32'(fv), 32'd1);
    cyc(0, 0, 1, 0, 1, 32'hFFFF_FFFC);
    chk("pc top", pc, 32'hFFFF_FFFC);
    chk("pc_plus4 wrap", pcPlus4, 32'h0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("pc wrap", pc, 32'h0);

    // Trap, reach 0x30, stall into HOLD, reset there.
    cyc(0, 0, 1, 0, 1, 32'h2);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 1, 32'h30);
    cyc(0, 1, 0, 0, 1, 0);
    chk("hold pc", pc, 32'h30);
    cyc(1, 1, 0, 0, 1, 0);
    chk("rst hold pc", pc, RST_PC);
    chk("rst hold mis", 32'(mis), 32'd0);
`ifdef PC_STATS_EN
    chk("rst acc cnt", accCnt, 32'd0);
    chk("rst taken cnt", takCnt, 32'd0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic        r, st, b, j, rd;
      logic [31:0] t;
      r  = ($urandom_range(0, 99) == 0);
      st = ($urandom_range(0, 3) == 0);
      b  = ($urandom_range(0, 2) == 0);
      j  = $urandom_range(0, 1) == 1;
      rd = ($urandom_range(0, 3) != 0);
      t  = $urandom;
      case ($urandom_range(0, 5))
        0, 1, 2: t = t & ~32'h3;
        3:       t = (t & ~32'h3) | 32'h1;
        4:       t = 32'hFFFF_FFFC;
        default: ;
      endcase
      cyc(r, st, b, j, rd, t);
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
